// File: rtl/shared_rand_pkg.sv
// Shared constants for the fresh-randomness (Z) producer: LFSR geometry,
// feedback taps, zero-seed substitute and FSM state encoding.
package shared_rand_pkg;

  localparam int LFSR_W = 32;

  // Feedback taps of x^32 + x^22 + x^2 + x + 1 (Fibonacci form)
  localparam int TAP_3 = 31;
  localparam int TAP_2 = 21;
  localparam int TAP_1 = 1;
  localparam int TAP_0 = 0;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by this
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

  // FSM state encoding
  localparam logic [1:0] SEED_WAIT = 2'd0;
  localparam logic [1:0] WARMUP    = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  // Feedback bit of one LFSR step
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_3] ^ s[TAP_2] ^ s[TAP_1] ^ s[TAP_0];
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// Combinational STEPS-fold unrolled advance of the 32-bit Fibonacci LFSR.
module lfsr32_step
  import shared_rand_pkg::*;
#(
  parameter int STEPS = 2
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] s;

  // Shift in the feedback bit STEPS times within the same cycle
  always_comb begin
    s = state_i;
    for (int i = 0; i < STEPS; i++) begin
      s = {s[LFSR_W-2:0], lfsr_fb(s)};
    end
    state_o = s;
  end

endmodule

// File: rtl/shared_rand_src.sv
// Fresh-randomness producer for DOM shared multipliers: seeded LFSR,
// warm-up discard, single-entry valid/ready output register and a
// sticky reseed request after RESEED_PERIOD accepted words.
module shared_rand_src
  import shared_rand_pkg::*;
#(
  parameter int SHARES        = 2,
  parameter int WARMUP_CYCLES = 16,
  parameter int RESEED_PERIOD = 1024
) (
  input  logic                           ClkxCI,
  input  logic                           RstxRI,
  input  logic [31:0]                    SeedxDI,
  input  logic                           SeedValidxSI,
  output logic [SHARES*(SHARES-1)-1:0]   ZxDO,
  output logic                           ZValidxSO,
  input  logic                           ZReadyxSI,
  output logic                           ReseedReqxSO,
  output logic                           BusyxSO
);

  localparam int ZW    = SHARES * (SHARES - 1);
  localparam int CNT_W = (RESEED_PERIOD < 2) ? 1 : $clog2(RESEED_PERIOD + 1);
  localparam logic [CNT_W-1:0] RP_C    = CNT_W'(RESEED_PERIOD);
  localparam logic [7:0]       WU_LAST = 8'(WARMUP_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [ZW-1:0]     z_q, z_d;
  logic              zvalid_q, zvalid_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [7:0]        wu_cnt_q, wu_cnt_d;
  logic              reseed_q, reseed_d;
  logic              busy_q, busy_d;
  logic              fill_s;
  logic              accept_s;

  lfsr32_step #(.STEPS(ZW)) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_adv)
  );

  // Next-state logic: seed load has priority over every state
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    z_d      = z_q;
    zvalid_d = zvalid_q;
    wcnt_d   = wcnt_q;
    wu_cnt_d = wu_cnt_q;
    reseed_d = reseed_q;
    fill_s   = 1'b0;
    accept_s = 1'b0;

    if (SeedValidxSI) begin
      // A pending word is dropped here even if the consumer is ready
      lfsr_d   = (SeedxDI == 32'h0000_0000) ? ZERO_SEED_SUB : SeedxDI;
      zvalid_d = 1'b0;
      wcnt_d   = '0;
      reseed_d = 1'b0;
      wu_cnt_d = 8'd0;
      state_d  = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
    end else begin
      case (state_q)
        SEED_WAIT: begin
          zvalid_d = 1'b0;
        end
        WARMUP: begin
          lfsr_d = lfsr_adv;
          if (wu_cnt_q == WU_LAST) begin
            state_d  = RUN;
            wu_cnt_d = 8'd0;
          end else begin
            wu_cnt_d = wu_cnt_q + 8'd1;
          end
        end
        RUN: begin
          accept_s = zvalid_q & ZReadyxSI;
          fill_s   = ~zvalid_q | ZReadyxSI;
          if (fill_s) begin
            // The LFSR only moves when a word is actually loaded
            lfsr_d   = lfsr_adv;
            z_d      = lfsr_adv[ZW-1:0];
            zvalid_d = 1'b1;
          end else begin
            lfsr_d   = lfsr_q;
            z_d      = z_q;
            zvalid_d = zvalid_q;
          end
          if (accept_s && (RESEED_PERIOD != 0) && (wcnt_q != RP_C)) begin
            wcnt_d = wcnt_q + CNT_W'(1);
          end else begin
            wcnt_d = wcnt_q;
          end
          if ((RESEED_PERIOD != 0) && (wcnt_d == RP_C)) begin
            reseed_d = 1'b1;
          end else begin
            reseed_d = reseed_q;
          end
        end
        default: begin
          state_d  = SEED_WAIT;
          zvalid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != RUN);
  end

  // State, LFSR, counters and output register
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      state_q  <= SEED_WAIT;
      lfsr_q   <= ZERO_SEED_SUB;
      z_q      <= '0;
      zvalid_q <= 1'b0;
      wcnt_q   <= '0;
      wu_cnt_q <= 8'd0;
      reseed_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      z_q      <= z_d;
      zvalid_q <= zvalid_d;
      wcnt_q   <= wcnt_d;
      wu_cnt_q <= wu_cnt_d;
      reseed_q <= reseed_d;
      busy_q   <= busy_d;
    end
  end

  assign ZxDO         = z_q;
  assign ZValidxSO    = zvalid_q;
  assign ReseedReqxSO = reseed_q;
  assign BusyxSO      = busy_q;

endmodule

// File: tb/tb_shared_rand_src.sv
// Directed bench for shared_rand_src: instance A (no warm-up, reseed period 4)
// and instance B (16-cycle warm-up, default reseed period).
module tb_shared_rand_src;

  logic clk;
  logic rst;

  logic [31:0] seed_a, seed_b;
  logic        sv_a, sv_b, rdy_a, rdy_b;
  logic [1:0]  z_a, z_b;
  logic        zv_a, zv_b, rr_a, rr_b, busy_a, busy_b;

  int checks;
  int failures;

  logic [31:0] m_state;
  logic [1:0]  held;

  shared_rand_src #(.SHARES(2), .WARMUP_CYCLES(0), .RESEED_PERIOD(4)) dut_a (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_a), .SeedValidxSI(sv_a),
    .ZxDO(z_a), .ZValidxSO(zv_a), .ZReadyxSI(rdy_a),
    .ReseedReqxSO(rr_a), .BusyxSO(busy_a)
  );

  shared_rand_src #(.SHARES(2), .WARMUP_CYCLES(16), .RESEED_PERIOD(1024)) dut_b (
    .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed_b), .SeedValidxSI(sv_b),
    .ZxDO(z_b), .ZValidxSO(zv_b), .ZReadyxSI(rdy_b),
    .ReseedReqxSO(rr_b), .BusyxSO(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: n single steps of x^32+x^22+x^2+x+1
  function automatic logic [31:0] model_adv(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < n; i++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    seed_a = 32'h0; seed_b = 32'h0;
    sv_a   = 1'b0;  sv_b   = 1'b0;
    rdy_a  = 1'b0;  rdy_b  = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_zv_a",   {31'd0, zv_a},   32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst_rr_a",   {31'd0, rr_a},   32'd0);
    chk("rst_z_a",    {30'd0, z_a},    32'd0);
    chk("rst_zv_b",   {31'd0, zv_b},   32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd1);
    rst = 1'b0;
    tick();
    chk("seedwait_zv_a", {31'd0, zv_a}, 32'd0);

    // A: seed 1, continuous accept, reseed request after 4 transfers
    rdy_a = 1'b1; seed_a = 32'h1; sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    chk("a_seed_zv",   {31'd0, zv_a},   32'd0);
    chk("a_seed_busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("a_w1_zv", {31'd0, zv_a}, 32'd1);
    chk("a_w1",    {30'd0, z_a},  32'd2);
    tick();
    chk("a_w2",    {30'd0, z_a},  32'd3);
    tick();
    chk("a_w3",    {30'd0, z_a},  32'd1);
    tick();
    chk("a_w4",    {30'd0, z_a},  32'd2);
    chk("a_rr_before", {31'd0, rr_a}, 32'd0);
    tick();
    chk("a_w5",    {30'd0, z_a},  32'd3);
    chk("a_rr_at_4th", {31'd0, rr_a}, 32'd1);
    tick();
    chk("a_rr_sticky", {31'd0, rr_a}, 32'd1);
    chk("a_zv_cont",   {31'd0, zv_a}, 32'd1);

    // A: zero seed behaves like seed 1, clears request, drops pending word
    seed_a = 32'h0; sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    chk("a_rs_zv", {31'd0, zv_a}, 32'd0);
    chk("a_rs_rr", {31'd0, rr_a}, 32'd0);
    tick();
    chk("a_z0_zv", {31'd0, zv_a}, 32'd1);
    chk("a_z0_w1", {30'd0, z_a},  32'd2);
    tick();
    chk("a_z0_w2", {30'd0, z_a},  32'd3);
    tick();
    chk("a_z0_w3", {30'd0, z_a},  32'd1);

    // B: 16-cycle warm-up from seed ACE12345
    rdy_b = 1'b1; seed_b = 32'hACE1_2345; sv_b = 1'b1;
    tick();
    sv_b = 1'b0;
    chk("b_seed_busy", {31'd0, busy_b}, 32'd1);
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk($sformatf("b_wu_zv_%0d", e), {31'd0, zv_b}, 32'd0);
      if (e < 16) begin
        chk($sformatf("b_wu_busy_%0d", e), {31'd0, busy_b}, 32'd1);
      end else begin
        chk("b_wu_busy_end", {31'd0, busy_b}, 32'd0);
      end
    end
    tick();
    m_state = model_adv(32'hACE1_2345, 17 * 2);
    chk("b_first_zv", {31'd0, zv_b}, 32'd1);
    chk("b_first_z",  {30'd0, z_b},  {30'd0, m_state[1:0]});

    // B: backpressure for 10 cycles
    held  = m_state[1:0];
    rdy_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("b_hold_z_%0d", c),  {30'd0, z_b},  {30'd0, held});
      chk($sformatf("b_hold_zv_%0d", c), {31'd0, zv_b}, 32'd1);
    end
    rdy_b = 1'b1;
    tick();
    m_state = model_adv(m_state, 2);
    chk("b_release_w1", {30'd0, z_b}, {30'd0, m_state[1:0]});
    tick();
    m_state = model_adv(m_state, 2);
    chk("b_release_w2", {30'd0, z_b}, {30'd0, m_state[1:0]});
    tick();
    m_state = model_adv(m_state, 2);
    chk("b_release_w3", {30'd0, z_b}, {30'd0, m_state[1:0]});

    // Asynchronous reset between clock edges while both run
    #3;
    rst = 1'b1;
    #1;
    chk("arst_zv_a",   {31'd0, zv_a},   32'd0);
    chk("arst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("arst_zv_b",   {31'd0, zv_b},   32'd0);
    chk("arst_busy_b", {31'd0, busy_b}, 32'd1);
    chk("arst_rr_a",   {31'd0, rr_a},   32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("arst_idle_zv_%0d", c), {31'd0, zv_a}, 32'd0);
    end

    // New seed after reset restarts output
    seed_a = 32'h1; sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    tick();
    chk("post_rst_zv", {31'd0, zv_a}, 32'd1);
    chk("post_rst_w1", {30'd0, z_a},  32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_rand_src.md
Name: shared_rand_src

Overview:
- Producer end of the fresh-randomness (Z) interface consumed by the DOM shared GF(2^2)/GF(2^4) multipliers of the masked AES S-box.
- Generates SHARES*(SHARES-1) fresh mask bits per transfer from a seeded 32-bit maximal-length LFSR.
- Sequencing: seed load, warm-up discard, then output through a single-entry valid/ready output register.
- Requests a reseed after a programmable number of delivered words.

Parameters:
- SHARES, 2, share count of the downstream multiplier. Output width ZW = SHARES*(SHARES-1). Legal range 2..6, so ZW ≤ 30.
- WARMUP_CYCLES, 16, LFSR advances discarded after each seed load. Legal range 0..255.
- RESEED_PERIOD, 1024, accepted words before ReseedReqxSO asserts. Value 0 disables the request.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxRI  in  1  reset.
- SeedxDI  in  32  seed value.
- SeedValidxSI  in  1  load seed, sampled every edge.
- ZxDO  out  ZW  fresh randomness word, same bit layout as the multiplier's Z input.
- ZValidxSO  out  1  ZxDO holds an unconsumed word.
- ZReadyxSI  in  1  consumer accepts ZxDO.
- ReseedReqxSO  out  1  RESEED_PERIOD words delivered since last seed.
- BusyxSO  out  1  high in SEED_WAIT and WARMUP.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
  - Reset gives state SEED_WAIT, lfsr=32'h1, ZxDO=0, ZValidxSO=0, ReseedReqxSO=0, BusyxSO=1, counters=0.
- LFSR step (Fibonacci, x^32+x^22+x^2+x+1): new = s[31]^s[21]^s[1]^s[0]; s <= {s[30:0], new}.
- Advance = ZW steps unrolled within one cycle. Word = bits [ZW-1:0] of the post-advance state.
- Seed 32'h0 is forbidden and is loaded as 32'h1.
- States:
  - SEED_WAIT: outputs idle; waits for SeedValidxSI.
  - WARMUP: one advance per cycle; warm-up counter counts 0..WARMUP_CYCLES-1; goes to RUN after the last one. With WARMUP_CYCLES=0, seed load goes directly to RUN.
  - RUN:
    - If ZValidxSO=0, or ZValidxSO=1 and ZReadyxSI=1: advance, load the word into ZxDO, set ZValidxSO=1.
    - Otherwise hold ZxDO, ZValidxSO and the LFSR unchanged. ZxDO must not change while ZValidxSO=1 and not accepted.
    - LFSR does not advance without a fill; no word is ever skipped or duplicated.
- Latency:
  - First ZValidxSO rises on edge WARMUP_CYCLES+1 after the edge that sampled SeedValidxSI.
  - With continuous ZReadyxSI=1, one new word per cycle.
- Seed load in any state (SeedValidxSI=1 at an edge):
  - lfsr <= seed, clear ZValidxSO, clear word counter, clear ReseedReqxSO, clear warm-up counter, go to WARMUP (or RUN if WARMUP_CYCLES=0).
  - A word pending at that edge is discarded even if ZReadyxSI=1. The consumer must not count it as transferred.
- Word counter:
  - Increments on each accepted transfer (ZValidxSO & ZReadyxSI).
  - Saturates at RESEED_PERIOD; ReseedReqxSO=1 from the edge it reaches RESEED_PERIOD.
  - Output continues while ReseedReqxSO=1; ReseedReqxSO clears only on seed load or reset.
- Reset mid-operation: immediate return to reset values. Any pending word is lost.

Decomposition:
- Package shared_rand_pkg holds:
  - LFSR_W=32.
  - Tap constants {31,21,1,0}.
  - Zero-seed substitute 32'h1.
  - State encoding SEED_WAIT=2'd0, WARMUP=2'd1, RUN=2'd2.
- Sub-module lfsr32_step: combinational, parameter STEPS, state in, state out. Instantiated once with STEPS=ZW.
- FSM, counters and output register live in shared_rand_src.

Test Plan:
- Reset with SHARES=2, WARMUP_CYCLES=0, then seed 32'h1 with ZReadyxSI=1 held:
  - ZValidxSO rises one edge after seed.
  - ZxDO sequence 2'b10, 2'b11, 2'b01 (states 0x6, 0x1B, 0x6D).
- Same setup but with seed 32'h0: output sequence identical to the seed 32'h1 case.
- WARMUP_CYCLES=16, seed 32'hACE1_2345:
  - BusyxSO=1 and ZValidxSO=0 for 16 edges; ZValidxSO=1 at edge 17.
  - ZxDO matches the reference model after 17 advances.
- Backpressure:
  - Hold ZReadyxSI=0 for 10 cycles: ZxDO stable, LFSR frozen.
  - Release: the next word equals the model's next word, no skip.
- RESEED_PERIOD=4 with continuous accept:
  - ReseedReqxSO rises on the edge of the 4th transfer.
  - A new seed clears it and drops ZValidxSO for WARMUP_CYCLES+1 edges.
- Assert RstxRI asynchronously mid-RUN between clock edges:
  - ZValidxSO=0 and BusyxSO=1 immediately.
  - No ZValidxSO until a new seed arrives.
